debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the sequential flop blocks (dff_sync / dff_async) and drives their i_data.
- Takes a raw asynchronous, bouncy input (button or switch) and synchronizes it to clk through a flop chain.
- Filters the synchronized level with a stability counter and FSM.
- Emits a clean level plus single-cycle rise/fall pulses.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new level; must be >= 2.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  1  raw asynchronous input; may glitch at any time.
- o_data  output  1  debounced, synchronized level; feeds the downstream flop i_data.
- o_rise  output  1  one-cycle pulse when o_data goes 0->1.
- o_fall  output  1  one-cycle pulse when o_data goes 1->0.
- o_busy  output  1  high while the FSM is in either WAIT state.

Behaviour:
- Clocking and reset (already decided): one clock (clk); reset i_rst is asynchronous and active-high.
- On i_rst=1, immediately, without waiting for a clock edge:
  - all sync flops = 0, state = S_LOW, cnt = 0
  - o_data = 0, o_rise = 0, o_fall = 0, o_busy = 0
  - o_toggle = 0 (if present)
- Reset deassertion takes effect at the next rising edge.
- Synchronizer: i_data shifts through SYNC_STAGES flops each edge. s denotes the last flop's output.
- All outputs are registered; no combinational path from i_data to any output.
- FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
- S_LOW:
  - s=1 -> S_WAIT_HIGH, cnt=1.
  - else stay.
- S_WAIT_HIGH:
  - s=0 -> S_LOW, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, o_data=1, o_rise=1, cnt=0.
  - otherwise cnt=cnt+1.
- S_HIGH and S_WAIT_LOW: mirror image of the above (s=0 counts toward release; s=1 in S_WAIT_LOW returns to S_HIGH). Acceptance sets o_data=0, o_fall=1.
- o_rise and o_fall are high for exactly one cycle and are never both high in the same cycle.
- o_busy=1 exactly when state is S_WAIT_HIGH or S_WAIT_LOW.
- Latency: count edges from the first edge that samples a stable new i_data value as edge 1. o_data changes after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults). The pulse is asserted in that same cycle.
- Any bounce shorter than DEBOUNCE_CYCLES synchronized samples leaves o_data unchanged.
- cnt never wraps: it is cleared on every state exit, and its maximum value is DEBOUNCE_CYCLES-1.
- Reset mid-count or mid-pulse: the pulse is cut off immediately. After release, o_data is 0, even if i_data is held at 1. A held 1 is re-qualified with the full latency, and produces o_rise.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined:
  - adds output port o_toggle (1 bit, reset 0), which inverts on every cycle that o_rise=1
  - turns a momentary button into an on/off level
  - o_toggle updates in the same edge as o_rise
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert i_rst=1 mid-cycle with i_data=1 -> all outputs 0 immediately, without waiting for a clock edge; hold i_data=1 after release -> o_data=1 and o_rise=1 after edge 6.
- Clean press: i_data 0->1 held for 10 cycles -> o_data rises after edge 6; o_rise is high for exactly 1 cycle; o_busy is high for 3 cycles before the rise.
- Glitch rejection: i_data=1 for 3 cycles then 0 -> o_data stays 0, no o_rise, o_busy returns to 0.
- Bouncy release: from o_data=1, i_data toggles 1,0,1,0,0,0,0,0 (one value per cycle) -> exactly one o_fall, and o_data=0 only after 4 consecutive synchronized 0 samples.
- Random stimulus: 200 cycles of i_data with random hold lengths 1..8 -> o_data matches the reference model; the number of o_rise pulses equals the number of accepted 0->1 transitions; o_rise and o_fall are never high together.
- DEBOUNCE_TOGGLE_EN defined, 3 clean presses -> o_toggle goes 0->1->0->1, each change aligned with an o_rise pulse.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw, bouncy asynchronous input (button or switch)
// for the downstream sequential flop blocks. The input is brought into the clk
// domain through a SYNC_STAGES-deep flop chain. A four-state FSM with a
// stability counter then accepts a new level only after DEBOUNCE_CYCLES
// consecutive identical synchronized samples. Outputs are a clean level plus
// single-cycle rise/fall pulses, and a busy flag while a candidate level is
// being qualified.
//
// Optional build macro DEBOUNCE_TOGGLE_EN adds o_toggle, a level that inverts
// on every accepted rising edge, turning a momentary button into an on/off
// switch.

module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_data,
    output logic o_data,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic o_toggle
`endif
);

    localparam logic [1:0] S_LOW       = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH      = 2'd2;
    localparam logic [1:0] S_WAIT_LOW  = 2'd3;

    // The sample that completes qualification arrives when cnt holds this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   data_next;
    logic                   rise_next;
    logic                   fall_next;

    assign s = sync[SYNC_STAGES-1];

    // Synchronizer chain: shift the raw input in one stage per clock.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_data};
        end
    end

    // Next-state logic: a differing sample starts qualification, any return to the
    // current level abandons it, and a full run of samples accepts the new level.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = o_data;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            S_LOW: begin
                if (s) begin
                    state_next = S_WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                    data_next  = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_next = S_WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                    data_next  = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
                data_next  = 1'b0;
            end
        endcase
    end

    // FSM state, counter and all registered outputs; busy follows the state being entered.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_LOW;
            cnt    <= '0;
            o_data <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            o_data <= data_next;
            o_rise <= rise_next;
            o_fall <= fall_next;
            o_busy <= (state_next == S_WAIT_HIGH) || (state_next == S_WAIT_LOW);
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // Toggle level flips on the same edge that raises o_rise.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_toggle <= 1'b0;
        end else if (rise_next) begin
            o_toggle <= ~o_toggle;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed and random-hold stimulus for debounce_sync.
// Directed sections carry hand-computed expectations per clock edge; the random
// section compares against a sliding-window reference model. Define
// DEBOUNCE_TOGGLE_EN to also exercise the o_toggle output.

module tb_debounce_sync;

    localparam int SS = 2;
    localparam int DC = 4;

    logic clk;
    logic i_rst;
    logic i_data;
    logic o_data;
    logic o_rise;
    logic o_fall;
    logic o_busy;
`ifdef DEBOUNCE_TOGGLE_EN
    logic o_toggle;
`endif

    int n_compared;
    int n_mismatched;

    logic [SS-1:0] m_sync;
    logic [DC-1:0] m_hist;
    logic          exp_data;
    logic          exp_rise;
    logic          exp_fall;
    logic          exp_busy;
    logic          exp_toggle;
    int            exp_rise_count;
    int            dut_rise_count;

    debounce_sync #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_busy  (o_busy)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .o_toggle(o_toggle)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one input value for one clock edge, advance the reference model,
    // and return 1 time unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic value);
        logic s_now;
        logic accept;
        i_data = value;
        @(posedge clk);
        s_now  = m_sync[SS-1];
        m_sync = {m_sync[SS-2:0], value};
        m_hist = {m_hist[DC-2:0], s_now};
        accept = exp_data ? (m_hist == '0) : (m_hist == '1);
        exp_rise = accept && !exp_data;
        exp_fall = accept && exp_data;
        if (accept) exp_data = !exp_data;
        if (exp_rise) begin
            exp_toggle = !exp_toggle;
            exp_rise_count++;
        end
        exp_busy = (s_now != exp_data);
        #1;
        if (o_rise) dut_rise_count++;
    endtask

    // Pulse reset mid-cycle and confirm every output clears without a clock edge.
    task automatic resetDut(input string tag);
        #2 i_rst = 1'b1;
        #1;
        checkOutput({tag, "_data"}, int'(o_data), 0);
        checkOutput({tag, "_rise"}, int'(o_rise), 0);
        checkOutput({tag, "_fall"}, int'(o_fall), 0);
        checkOutput({tag, "_busy"}, int'(o_busy), 0);
`ifdef DEBOUNCE_TOGGLE_EN
        checkOutput({tag, "_toggle"}, int'(o_toggle), 0);
`endif
        m_sync     = '0;
        m_hist     = '0;
        exp_data   = 1'b0;
        exp_rise   = 1'b0;
        exp_fall   = 1'b0;
        exp_busy   = 1'b0;
        exp_toggle = 1'b0;
        #2 i_rst = 1'b0;
    endtask

    initial begin
        logic bounce [10];
        logic v;
        int   len;
        int   n_cycles;
        int   n_falls;

        n_compared     = 0;
        n_mismatched   = 0;
        exp_rise_count = 0;
        dut_rise_count = 0;
        i_rst  = 1'b0;
        i_data = 1'b0;
        #1;
        resetDut("por");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0);

        // Qualify a held 1, then hit reset in the cycle the rise pulse is high.
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1);
        checkOutput("pre_reset_data", int'(o_data), 1);
        checkOutput("pre_reset_rise", int'(o_rise), 1);
        resetDut("mid_rst");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1);
            checkOutput("requal_data", int'(o_data), int'(k >= 6));
            checkOutput("requal_rise", int'(o_rise), int'(k == 6));
            checkOutput("requal_busy", int'(o_busy), int'(k >= 3 && k <= 5));
        end

        // Bouncy release from a settled high level.
        bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_falls = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(bounce[k-1]);
            if (o_fall) n_falls++;
            checkOutput("bounce_data", int'(o_data), int'(k < 9));
            checkOutput("bounce_fall", int'(o_fall), int'(k == 9));
            checkOutput("bounce_busy", int'(o_busy), int'(k == 4 || (k >= 6 && k <= 8)));
        end
        checkOutput("bounce_fall_count", n_falls, 1);

        // Clean press held for 10 cycles, then released.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1);
            checkOutput("press_data", int'(o_data), int'(k >= 6));
            checkOutput("press_rise", int'(o_rise), int'(k == 6));
            checkOutput("press_busy", int'(o_busy), int'(k >= 3 && k <= 5));
        end
        for (int k = 1; k <= 10; k++) applyStimulus(1'b0);
        checkOutput("release_data", int'(o_data), 0);

        // Three-cycle glitch must be rejected.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(k <= 3 ? 1'b1 : 1'b0);
            checkOutput("glitch_data", int'(o_data), 0);
            checkOutput("glitch_rise", int'(o_rise), 0);
            checkOutput("glitch_busy", int'(o_busy), int'(k >= 3 && k <= 5));
        end

        // Random hold lengths against the reference model.
        exp_rise_count = 0;
        dut_rise_count = 0;
        n_cycles = 0;
        v = 1'b0;
        while (n_cycles < 200) begin
            v   = !v;
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len && n_cycles < 200; j++) begin
                applyStimulus(v);
                n_cycles++;
                checkOutput("rand_data", int'(o_data), int'(exp_data));
                checkOutput("rand_rise", int'(o_rise), int'(exp_rise));
                checkOutput("rand_fall", int'(o_fall), int'(exp_fall));
                checkOutput("rand_busy", int'(o_busy), int'(exp_busy));
                checkOutput("rand_excl", int'(o_rise & o_fall), 0);
`ifdef DEBOUNCE_TOGGLE_EN
                checkOutput("rand_toggle", int'(o_toggle), int'(exp_toggle));
`endif
            end
        end
        checkOutput("rand_rise_count", dut_rise_count, exp_rise_count);

`ifdef DEBOUNCE_TOGGLE_EN
        // Three clean presses from reset: toggle goes 0->1->0->1 on each rise.
        resetDut("tog_rst");
        for (int p = 0; p < 3; p++) begin
            for (int k = 1; k <= 8; k++) begin
                applyStimulus(1'b1);
                if (k == 5) checkOutput("tog_before", int'(o_toggle), p % 2);
                if (k == 6) begin
                    checkOutput("tog_after", int'(o_toggle), (p + 1) % 2);
                    checkOutput("tog_rise", int'(o_rise), 1);
                end
            end
            for (int k = 1; k <= 8; k++) applyStimulus(1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
